// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads one- or two-word instructions from MEM2,
// hands complete bundles to decode over valid/ready, and handles redirects
// and the STP halt.
module instr_fetch #(
  parameter int unsigned        ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_r_nwb,
  input  logic [15:0]       mem_rdata,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [15:0]       ir_word,
  output logic [15:0]       ir_imm,
  output logic              ir_two_word,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam int unsigned OPC_W = 8;
  localparam logic [OPC_W-1:0] OPC_STP = 8'hFF;

  typedef enum logic [1:0] {
    S_FETCH_OP  = 2'd0,
    S_FETCH_IMM = 2'd1,
    S_HOLD      = 2'd2,
    S_HALT      = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_ir_valid;
  logic [15:0]       r_ir_word;
  logic [15:0]       r_ir_imm;
  logic              r_ir_two_word;
  logic [ADDR_W-1:0] r_ir_pc;
  logic              r_halted;

  logic              w_fetching;
  logic              w_two_word;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_redirect_pc;

  // Memory-side request is combinational from state/pc, suppressed during reset.
  assign w_fetching    = (r_state == S_FETCH_OP) || (r_state == S_FETCH_IMM);
  assign mem_req       = w_fetching && !rst;
  assign mem_addr      = r_pc;
  assign mem_r_nwb     = 1'b1;
  assign w_pc_next     = r_pc + ADDR_W'(2);
  assign w_redirect_pc = redirect_pc & ~ADDR_W'(1);

  // Decode the incoming opcode byte for instruction length.
  always_comb begin
    w_two_word = 1'b0;
    case (mem_rdata[15:8])
      8'h02, 8'h04, 8'h0A, 8'h0C, 8'h15, 8'h24: w_two_word = 1'b1;
      default:                                  w_two_word = 1'b0;
    endcase
  end

  // Fetch FSM with registered bundle outputs; redirect preempts everything but reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_FETCH_OP;
      r_pc          <= RESET_PC;
      r_ir_valid    <= 1'b0;
      r_ir_word     <= '0;
      r_ir_imm      <= '0;
      r_ir_two_word <= 1'b0;
      r_ir_pc       <= '0;
      r_halted      <= 1'b0;
    end else if (redirect && (r_state != S_HALT)) begin
      r_state       <= S_FETCH_OP;
      r_pc          <= w_redirect_pc;
      r_ir_valid    <= 1'b0;
      r_ir_two_word <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH_OP: begin
          if (mem_gnt) begin
            r_ir_word     <= mem_rdata;
            r_ir_pc       <= r_pc;
            r_ir_imm      <= '0;
            r_pc          <= w_pc_next;
            r_ir_two_word <= w_two_word;
            if (w_two_word) begin
              r_state <= S_FETCH_IMM;
            end else begin
              r_state    <= S_HOLD;
              r_ir_valid <= 1'b1;
            end
          end
        end
        S_FETCH_IMM: begin
          if (mem_gnt) begin
            r_ir_imm   <= mem_rdata;
            r_pc       <= w_pc_next;
            r_state    <= S_HOLD;
            r_ir_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (ir_ready) begin
            r_ir_valid <= 1'b0;
            if (r_ir_word[15:8] == OPC_STP) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_state <= S_FETCH_OP;
            end
          end
        end
        S_HALT: begin
          r_ir_valid <= 1'b0;
        end
        default: begin
          r_state <= S_FETCH_OP;
        end
      endcase
    end
  end

  assign pc          = r_pc;
  assign ir_valid    = r_ir_valid;
  assign ir_word     = r_ir_word;
  assign ir_imm      = r_ir_imm;
  assign ir_two_word = r_ir_two_word;
  assign ir_pc       = r_ir_pc;
  assign halted      = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a byte-addressed big-endian memory model.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic        mem_gnt;
  logic [15:0] mem_addr;
  logic        mem_r_nwb;
  logic [15:0] mem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] ir_word;
  logic [15:0] ir_imm;
  logic        ir_two_word;
  logic [15:0] ir_pc;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] pc;
  logic        halted;

  logic [7:0]  mem [0:65535];
  int          n_checks;
  int          n_pass;

  instr_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .mem_r_nwb(mem_r_nwb), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_word(ir_word),
    .ir_imm(ir_imm), .ir_two_word(ir_two_word), .ir_pc(ir_pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .pc(pc), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational big-endian word read.
  assign mem_rdata = {mem[mem_addr], mem[16'(mem_addr + 16'd1)]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input logic [15:0] a, input logic [15:0] w);
    mem[a]               = w[15:8];
    mem[16'(a + 16'd1)]  = w[7:0];
  endtask

  // Safety net against a stuck run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    put_word(16'h0000, 16'h1201);
    put_word(16'h0002, 16'h0000);
    put_word(16'h0004, 16'h1302);
    put_word(16'h0006, 16'h0A01);
    put_word(16'h0008, 16'h0108);
    put_word(16'h000A, 16'h0C00);
    put_word(16'h000C, 16'h00FF);
    put_word(16'h0020, 16'h2400);
    put_word(16'h0022, 16'h0040);
    put_word(16'h002E, 16'h1305);
    put_word(16'h0030, 16'h1402);
    put_word(16'h0044, 16'hFF00);
    put_word(16'hFFFE, 16'h1234);

    rst = 1'b1; mem_gnt = 1'b1; ir_ready = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000;
    tick(); tick();
    chk("rst_valid", 32'(ir_valid), 32'd0);
    chk("rst_pc", 32'(pc), 32'h0000);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_word", 32'(ir_word), 32'h0000);
    chk("rst_memreq", 32'(mem_req), 32'd0);
    chk("r_nwb", 32'(mem_r_nwb), 32'd1);

    rst = 1'b0; #1;
    chk("op_req", 32'(mem_req), 32'd1);
    chk("op_addr", 32'(mem_addr), 32'h0000);
    tick();
    chk("add_valid", 32'(ir_valid), 32'd1);
    chk("add_word", 32'(ir_word), 32'h1201);
    chk("add_two", 32'(ir_two_word), 32'd0);
    chk("add_pc", 32'(ir_pc), 32'h0000);
    chk("add_imm", 32'(ir_imm), 32'h0000);
    chk("hold_req", 32'(mem_req), 32'd0);
    tick();
    chk("add_accept", 32'(ir_valid), 32'd0);
    chk("next_addr", 32'(mem_addr), 32'h0002);
    tick(); tick(); tick(); tick();

    chk("ori_addr", 32'(mem_addr), 32'h0006);
    tick();
    chk("ori_midvalid", 32'(ir_valid), 32'd0);
    chk("ori_immaddr", 32'(mem_addr), 32'h0008);
    tick();
    chk("ori_valid", 32'(ir_valid), 32'd1);
    chk("ori_word", 32'(ir_word), 32'h0A01);
    chk("ori_imm", 32'(ir_imm), 32'h0108);
    chk("ori_two", 32'(ir_two_word), 32'd1);
    chk("ori_pc", 32'(ir_pc), 32'h0006);
    chk("ori_pcafter", 32'(pc), 32'h000A);

    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", 32'(ir_valid), 32'd1);
      chk("bp_word", 32'(ir_word), 32'h0A01);
      chk("bp_req", 32'(mem_req), 32'd0);
    end
    ir_ready = 1'b1;
    tick();
    chk("bp_release", 32'(ir_valid), 32'd0);

    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("gs_addr", 32'(mem_addr), 32'h000C);
      chk("gs_valid", 32'(ir_valid), 32'd0);
      chk("gs_req", 32'(mem_req), 32'd1);
    end
    mem_gnt = 1'b1;
    tick();
    chk("andi_valid", 32'(ir_valid), 32'd1);
    chk("andi_word", 32'(ir_word), 32'h0C00);
    chk("andi_imm", 32'(ir_imm), 32'h00FF);
    tick();

    redirect = 1'b1; redirect_pc = 16'h0020;
    tick();
    redirect = 1'b0;
    chk("rd1_addr", 32'(mem_addr), 32'h0020);
    tick();
    redirect = 1'b1; redirect_pc = 16'h002E;
    tick();
    redirect = 1'b0;
    chk("rdj_valid", 32'(ir_valid), 32'd0);
    chk("rdj_two", 32'(ir_two_word), 32'd0);
    chk("rdj_addr", 32'(mem_addr), 32'h002E);
    tick();
    chk("sub_pc", 32'(ir_pc), 32'h002E);
    chk("sub_word", 32'(ir_word), 32'h1305);
    chk("sub_imm", 32'(ir_imm), 32'h0000);
    chk("sub_two", 32'(ir_two_word), 32'd0);

    redirect = 1'b1; redirect_pc = 16'h0031;
    tick();
    redirect = 1'b0;
    chk("rdodd_valid", 32'(ir_valid), 32'd0);
    chk("rdodd_addr", 32'(mem_addr), 32'h0030);
    tick();
    chk("mult_pc", 32'(ir_pc), 32'h0030);
    chk("mult_word", 32'(ir_word), 32'h1402);
    tick();

    redirect = 1'b1; redirect_pc = 16'h0044;
    tick();
    redirect = 1'b0;
    tick();
    chk("stp_word", 32'(ir_word), 32'hFF00);
    tick();
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_valid", 32'(ir_valid), 32'd0);
    chk("halt_req", 32'(mem_req), 32'd0);
    chk("halt_pc", 32'(pc), 32'h0046);
    tick();
    redirect = 1'b1; redirect_pc = 16'h0010;
    tick();
    redirect = 1'b0;
    chk("halt_rd_pc", 32'(pc), 32'h0046);
    chk("halt_rd_flag", 32'(halted), 32'd1);
    chk("halt_rd_req", 32'(mem_req), 32'd0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("unhalt_pc", 32'(pc), 32'h0000);
    chk("unhalt_flag", 32'(halted), 32'd0);

    redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    chk("wrap_addr", 32'(mem_addr), 32'hFFFE);
    tick();
    chk("wrap_word", 32'(ir_word), 32'h1234);
    chk("wrap_irpc", 32'(ir_pc), 32'hFFFE);
    chk("wrap_pc", 32'(pc), 32'h0000);
    tick();

    redirect = 1'b1; redirect_pc = 16'h0006;
    tick();
    redirect = 1'b0;
    tick();
    chk("mid_imm_addr", 32'(mem_addr), 32'h0008);
    rst = 1'b1; #1;
    chk("rst_req_force", 32'(mem_req), 32'd0);
    tick();
    rst = 1'b0; #1;
    chk("midrst_pc", 32'(pc), 32'h0000);
    chk("midrst_valid", 32'(ir_valid), 32'd0);
    chk("midrst_two", 32'(ir_two_word), 32'd0);
    chk("midrst_req", 32'(mem_req), 32'd1);
    tick();
    chk("midrst_word", 32'(ir_word), 32'h1201);
    chk("midrst_hold", 32'(ir_valid), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
